reg_file_sb: RTL and testbench

REG_FILE_SB -- requirements
Module: reg_file_sb

---
 rtl/reg_file_sb.sv | 99 +++++++++
 tb/tb_reg_file_sb.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// Multi-ported register file with a per-register busy (scoreboard) bit.
// Reads are combinational with write-through bypass; reservations mark registers as awaiting a producer.
module reg_file_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] RdAddr,
    output logic [NUM_RD*DATA_W-1:0] RdData,
    output logic [NUM_RD-1:0]        RdBusy,
    input  logic                     WrEn,
    input  logic [ADDR_W-1:0]        WrAddr,
    input  logic [DATA_W-1:0]        WrData,
    input  logic                     RsvEn,
    input  logic [ADDR_W-1:0]        RsvAddr,
    output logic                     RsvConflict,
    output logic [ADDR_W:0]          PendCnt
);

    localparam int DEPTH   = 2 ** ADDR_W;
    localparam bit HasZero = (ZERO_REG != 0);

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busyNext;
    logic [ADDR_W:0]   pendNext;

    logic wrAct;
    logic rsvAct;
    logic sameAddr;
    logic rsvReject;
    logic rsvInc;
    logic wrDec;

    // Accesses to a hardwired zero register are dropped here, so nothing downstream sees them.
    // Writes are also masked during reset so the bypass cannot leak data while rst_n is low.
    assign wrAct     = WrEn && rst_n && !(HasZero && (WrAddr == '0));
    assign rsvAct    = RsvEn && !(HasZero && (RsvAddr == '0));
    assign sameAddr  = wrAct && rsvAct && (WrAddr == RsvAddr);
    assign rsvReject = rsvAct && busy[RsvAddr] && !sameAddr;
    assign rsvInc    = rsvAct && !busy[RsvAddr];
    assign wrDec     = wrAct && busy[WrAddr] && !sameAddr;

    // The write clears first so a same-address reservation leaves the bit set.
    always_comb begin
        busyNext = busy;
        if (wrAct) begin
            busyNext[WrAddr] = 1'b0;
        end
        if (rsvAct && !rsvReject) begin
            busyNext[RsvAddr] = 1'b1;
        end
    end

    always_comb begin
        pendNext = PendCnt;
        case ({rsvInc, wrDec})
            2'b10:   pendNext = PendCnt + (ADDR_W+1)'(1);
            2'b01:   pendNext = PendCnt - (ADDR_W+1)'(1);
            default: pendNext = PendCnt;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                regs[k] <= '0;
            end
            busy        <= '0;
            PendCnt     <= '0;
            RsvConflict <= 1'b0;
        end else begin
            if (wrAct) begin
                regs[WrAddr] <= WrData;
            end
            busy        <= busyNext;
            PendCnt     <= pendNext;
            RsvConflict <= rsvReject;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : gRead
        logic [ADDR_W-1:0] addr;
        logic              isZero;
        logic              isBypass;

        assign addr     = RdAddr[i*ADDR_W +: ADDR_W];
        assign isZero   = HasZero && (addr == '0);
        assign isBypass = wrAct && (WrAddr == addr);

        assign RdData[i*DATA_W +: DATA_W] = isZero   ? '0     :
                                            isBypass ? WrData : regs[addr];
        assign RdBusy[i] = !isZero && !isBypass && busy[addr];
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: directed scenarios plus randomized traffic checked against
// an array-based model of registers, busy flags and the conflict pulse.
module tb_reg_file_sb;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_RD   = 2;
    localparam int DEPTH    = 32;
    localparam bit ZERO_REG = 1'b1;

    logic                     clk;
    logic                     rst_n;
    logic [NUM_RD*ADDR_W-1:0] rdAddr;
    logic [NUM_RD*DATA_W-1:0] rdData;
    logic [NUM_RD-1:0]        rdBusy;
    logic                     wrEn;
    logic [ADDR_W-1:0]        wrAddr;
    logic [DATA_W-1:0]        wrData;
    logic                     rsvEn;
    logic [ADDR_W-1:0]        rsvAddr;
    logic                     rsvConflict;
    logic [ADDR_W:0]          pendCnt;

    reg_file_sb #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .NUM_RD  (NUM_RD),
        .ZERO_REG(1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .RdAddr     (rdAddr),
        .RdData     (rdData),
        .RdBusy     (rdBusy),
        .WrEn       (wrEn),
        .WrAddr     (wrAddr),
        .WrData     (wrData),
        .RsvEn      (rsvEn),
        .RsvAddr    (rsvAddr),
        .RsvConflict(rsvConflict),
        .PendCnt    (pendCnt)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [DATA_W-1:0] mRegs [DEPTH];
    logic [DEPTH-1:0]  mBusy;
    logic              mConf;
    logic [DATA_W-1:0] exp_q [$];

    int chkCnt = 0;
    int errCnt = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chkCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        for (int k = 0; k < DEPTH; k++) mRegs[k] = '0;
        mBusy = '0;
        mConf = 1'b0;
    endtask

    function automatic logic writeOk();
        return wrEn && !(ZERO_REG && wrAddr == 0);
    endfunction

    // Compare every output against what the model says for the inputs now applied.
    task automatic modelCheck();
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] ed;
        logic              eb;
        for (int i = 0; i < NUM_RD; i++) begin
            a = rdAddr[i*ADDR_W +: ADDR_W];
            if (ZERO_REG && a == 0) begin
                ed = '0;
                eb = 1'b0;
            end else if (writeOk() && wrAddr == a) begin
                ed = wrData;
                eb = 1'b0;
            end else begin
                ed = mRegs[a];
                eb = mBusy[a];
            end
            exp_q.push_back(ed);
            check($sformatf("rdBusy%0d", i), 64'(rdBusy[i]), 64'(eb));
        end
        for (int i = 0; i < NUM_RD; i++) begin
            check($sformatf("rdData%0d", i), 64'(rdData[i*DATA_W +: DATA_W]), 64'(exp_q.pop_front()));
        end
        check("pendCnt", 64'(pendCnt), 64'($countones(mBusy)));
        check("rsvConflict", 64'(rsvConflict), 64'(mConf));
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic re, input logic [4:0] ra,
                         input logic [4:0] r0, input logic [4:0] r1);
        wrEn    = we;
        wrAddr  = wa;
        wrData  = wd;
        rsvEn   = re;
        rsvAddr = ra;
        rdAddr  = {r1, r0};
        #1;
        modelCheck();
    endtask

    // Advance one clock and apply the register-file rules to the model.
    task automatic clockEdge();
        logic wOk;
        logic rOk;
        logic conf;
        @(posedge clk);
        wOk  = writeOk();
        rOk  = rsvEn && !(ZERO_REG && rsvAddr == 0);
        conf = rOk && mBusy[rsvAddr] && !(wOk && wrAddr == rsvAddr);
        if (wOk) begin
            mRegs[wrAddr] = wrData;
            mBusy[wrAddr] = 1'b0;
        end
        if (rOk && !conf) mBusy[rsvAddr] = 1'b1;
        mConf = conf;
        @(negedge clk);
    endtask

    task automatic idle(input logic [4:0] r0, input logic [4:0] r1);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, r0, r1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic              we, re;
        logic [4:0]        wa, ra, r0, r1;
        logic [31:0]       wd;

        rst_n   = 1'b0;
        wrEn    = 1'b0;
        wrAddr  = '0;
        wrData  = '0;
        rsvEn   = 1'b0;
        rsvAddr = '0;
        rdAddr  = '0;
        modelReset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset state on every address and port
        for (int a = 0; a < DEPTH; a++) begin
            @(negedge clk);
            idle(5'(a), 5'(DEPTH - 1 - a));
            check("rst_data0", 64'(rdData[31:0]), 64'd0);
            check("rst_data1", 64'(rdData[63:32]), 64'd0);
            check("rst_busy", 64'(rdBusy), 64'd0);
        end
        check("rst_pend", 64'(pendCnt), 64'd0);

        // Write-through bypass on port 1
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0, 5'd5);
        check("bypass_p1", 64'(rdData[63:32]), 64'hDEADBEEF);
        clockEdge();
        idle(5'd5, 5'd5);
        check("wr5_p0", 64'(rdData[31:0]), 64'hDEADBEEF);
        check("wr5_p1", 64'(rdData[63:32]), 64'hDEADBEEF);

        // Reserve, conflicting re-reserve, then the producing write
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd7, 5'd7);
        clockEdge();
        idle(5'd7, 5'd0);
        check("rsv7_busy", 64'(rdBusy[0]), 64'd1);
        check("rsv7_pend", 64'(pendCnt), 64'd1);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd7, 5'd0);
        clockEdge();
        idle(5'd7, 5'd0);
        check("conf_pulse", 64'(rsvConflict), 64'd1);
        check("conf_pend", 64'(pendCnt), 64'd1);
        clockEdge();
        idle(5'd7, 5'd0);
        check("conf_drop", 64'(rsvConflict), 64'd0);
        drive(1'b1, 5'd7, 32'h12, 1'b0, 5'd0, 5'd7, 5'd0);
        clockEdge();
        idle(5'd7, 5'd0);
        check("wr7_pend", 64'(pendCnt), 64'd0);
        check("wr7_busy", 64'(rdBusy[0]), 64'd0);
        check("wr7_data", 64'(rdData[31:0]), 64'h12);

        // Same-cycle write and reservation on a busy register
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd3, 5'd0);
        clockEdge();
        drive(1'b1, 5'd3, 32'h55, 1'b1, 5'd3, 5'd3, 5'd0);
        clockEdge();
        idle(5'd3, 5'd0);
        check("wr_rsv3_data", 64'(rdData[31:0]), 64'h55);
        check("wr_rsv3_busy", 64'(rdBusy[0]), 64'd1);
        check("wr_rsv3_pend", 64'(pendCnt), 64'd1);
        check("wr_rsv3_conf", 64'(rsvConflict), 64'd0);

        // Register 0 ignores writes and reservations
        drive(1'b1, 5'd0, 32'hFFFF, 1'b1, 5'd0, 5'd0, 5'd0);
        check("zero_byp", 64'(rdData[31:0]), 64'd0);
        clockEdge();
        idle(5'd0, 5'd0);
        check("zero_data", 64'(rdData[63:32]), 64'd0);
        check("zero_busy", 64'(rdBusy), 64'd0);
        check("zero_pend", 64'(pendCnt), 64'd1);
        check("zero_conf", 64'(rsvConflict), 64'd0);

        // Write and reservation on different registers both land
        drive(1'b1, 5'd3, 32'h66, 1'b1, 5'd9, 5'd3, 5'd9);
        clockEdge();
        idle(5'd3, 5'd9);
        check("split_busy3", 64'(rdBusy[0]), 64'd0);
        check("split_busy9", 64'(rdBusy[1]), 64'd1);
        check("split_pend", 64'(pendCnt), 64'd1);

        // Reserve 1..4 then reset between edges
        for (int r = 1; r <= 4; r++) begin
            drive(1'b0, 5'd0, 32'd0, 1'b1, 5'(r), 5'd1, 5'd2);
            clockEdge();
        end
        idle(5'd1, 5'd5);
        check("pre_rst_pend", 64'(pendCnt), 64'd5);
        #2;
        rst_n = 1'b0;
        modelReset();
        #1;
        check("async_pend", 64'(pendCnt), 64'd0);
        check("async_busy", 64'(rdBusy), 64'd0);
        check("async_data", 64'(rdData[63:32]), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(5'd4, 5'd5);
        drive(1'b1, 5'd4, 32'hA5A5, 1'b1, 5'd2, 5'd4, 5'd2);
        clockEdge();
        idle(5'd4, 5'd2);
        check("post_rst_data", 64'(rdData[31:0]), 64'hA5A5);
        check("post_rst_busy", 64'(rdBusy[1]), 64'd1);

        // Randomized traffic on a narrow address range to force collisions
        for (int n = 0; n < 400; n++) begin
            we = 1'($urandom_range(0, 1));
            re = 1'($urandom_range(0, 1));
            wa = 5'($urandom_range(0, 7));
            ra = 5'($urandom_range(0, 7));
            wd = $urandom;
            r0 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 7));
            r1 = ($urandom_range(0, 3) == 0) ? ra : 5'($urandom_range(0, 7));
            drive(we, wa, wd, re, ra, r0, r1);
            clockEdge();
        end
        idle(5'd1, 5'd2);

        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end

endmodule
